// File: rtl/mem_pkg.sv
// Shared widths, owner encoding and FSM state type for the unified-memory arbiter.
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I port, D port and memory-side signals around the arbiter.
// master = the arbiter itself, slave = pipeline plus memory around it.
interface mem_arbiter_if;

    logic                        i_req;
    logic [mem_pkg::ADDR_W-1:0]  i_addr;
    logic [mem_pkg::DATA_W-1:0]  i_rdata;
    logic                        i_done;
    logic                        i_stall;

    logic                        d_req;
    logic                        d_wr;
    logic [mem_pkg::ADDR_W-1:0]  d_addr;
    logic [mem_pkg::DATA_W-1:0]  d_wdata;
    logic [mem_pkg::DATA_W-1:0]  d_rdata;
    logic                        d_done;
    logic                        d_stall;

    logic                        mem_en;
    logic                        mem_wr;
    logic [mem_pkg::ADDR_W-1:0]  mem_addr;
    logic [mem_pkg::DATA_W-1:0]  mem_wdata;
    logic [mem_pkg::DATA_W-1:0]  mem_rdata;
    logic                        busy;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that did not own last wins.
module rr_pick2
    import mem_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_e last_owner,
    output owner_e grant,
    output logic   grant_valid
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            if (last_owner == OWN_I) grant = OWN_D;
            else                     grant = OWN_I;
        end else if (req_d) begin
            grant = OWN_D;
        end else begin
            grant = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-fetch and D accesses onto one fixed-latency memory.
// Each access runs IDLE -> ACCESS (LAT+1 cycles) -> DONE -> IDLE.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LAT = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_e            state, state_nxt;
    owner_e            owner_q, last_owner, grant;
    logic              grant_valid;
    logic [3:0]        cnt;
    logic              cnt_hit;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              i_hit, d_hit;

    assign cnt_hit = (cnt == LAT_C);

    rr_pick2 u_pick (
        .req_i       (bus.i_req),
        .req_d       (bus.d_req),
        .last_owner  (last_owner),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the default at the top of each always_comb is what keeps it free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  if (cnt_hit)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE, so a requester still holding req in DONE is not re-granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_I;
            last_owner <= OWN_I;
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q    <= grant;
                        last_owner <= grant;
                        cnt        <= '0;
                        if (grant == OWN_D) begin
                            addr_q  <= bus.d_addr;
                            wr_q    <= bus.d_wr;
                            wdata_q <= bus.d_wdata;
                        end else begin
                            addr_q  <= bus.i_addr;
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_hit) rdata_q <= wr_q ? '0 : bus.mem_rdata;
                    else         cnt     <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        i_hit         = (state == DONE) && (owner_q == OWN_I);
        d_hit         = (state == DONE) && (owner_q == OWN_D);
        bus.mem_en    = (state == ACCESS) && (cnt == 4'd0);
        bus.mem_wr    = wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.busy      = (state != IDLE);
        bus.i_done    = i_hit;
        bus.d_done    = d_hit;
        bus.i_rdata   = i_hit ? rdata_q : '0;
        bus.d_rdata   = d_hit ? rdata_q : '0;
        bus.i_stall   = bus.i_req & ~i_hit;
        bus.d_stall   = bus.d_req & ~d_hit;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, hand-written
// arbitration/reset/LAT=1 sequences, and random traffic against a schedule model.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int DONE_AT = LAT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.LAT(LAT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_arbiter #(.LAT(1))   u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory storage seen by the memory responder, and the model's own copy.
    logic [15:0] mem_store [bit [15:0]];
    logic [15:0] model_mem [bit [15:0]];

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        return mem_store.exists(a) ? mem_store[a] : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : (a ^ 16'h5A5A);
    endfunction

    // Memory for the LAT=4 instance: read data is valid only in the cycle LAT after mem_en.
    int          rd_cnt = 0;
    logic [15:0] rd_val = '0;
    always @(negedge clk) begin
        logic hit;
        hit = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            hit = (rd_cnt == 0);
        end
        bus.mem_rdata = hit ? rd_val : 16'($urandom);
        if (bus.mem_en) begin
            if (bus.mem_wr) mem_store[bus.mem_addr] = bus.mem_wdata;
            else begin
                rd_val = mem_read(bus.mem_addr);
                rd_cnt = LAT;
            end
        end
    end

    // Memory for the LAT=1 instance (read-only contents).
    logic        rd1_pend = 1'b0;
    logic [15:0] rd1_val = '0;
    always @(negedge clk) begin
        bus1.mem_rdata = rd1_pend ? rd1_val : 16'($urandom);
        rd1_pend = bus1.mem_en && !bus1.mem_wr;
        rd1_val  = (bus1.mem_addr ^ 16'h5A5A);
    end

    task automatic clear_inputs();
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_wr = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0;
        bus1.d_req = 1'b0; bus1.d_wr = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    // Single request on one port; called at a drive point (#1 after a rising edge).
    task automatic run_txn(input vec_t v, input int idx);
        int          done_at = -1;
        int          en_at = -1;
        logic [15:0] rd = '0, en_addr = '0, en_wdata = '0;
        logic        en_wr = 1'b0, wrong_done = 1'b0, stall_bad = 1'b0;
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_wr = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr;
        end
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            @(negedge clk);
            if (bus.mem_en && en_at < 0) begin
                en_at = k; en_addr = bus.mem_addr; en_wr = bus.mem_wr; en_wdata = bus.mem_wdata;
            end
            if (v.is_d ? bus.d_done : bus.i_done) begin
                done_at = k;
                rd = v.is_d ? bus.d_rdata : bus.i_rdata;
            end
            if (v.is_d ? bus.i_done : bus.d_done) wrong_done = 1'b1;
            if ((v.is_d ? bus.d_stall : bus.i_stall) !== (k != DONE_AT)) stall_bad = 1'b1;
            @(posedge clk);
            #1;
            // Post-grant address/data changes must not reach the memory.
            if (k == 1) begin
                bus.i_addr = ~v.addr; bus.d_addr = ~v.addr; bus.d_wdata = ~v.wdata;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check($sformatf("t%0d_done_cycle", idx), 64'(done_at), 64'(DONE_AT));
        check($sformatf("t%0d_mem_en_cycle", idx), 64'(en_at), 64'd1);
        check($sformatf("t%0d_mem_addr", idx), en_addr, v.addr);
        check($sformatf("t%0d_mem_wr", idx), en_wr, v.wr);
        if (v.wr) check($sformatf("t%0d_mem_wdata", idx), en_wdata, v.wdata);
        check($sformatf("t%0d_rdata", idx), rd, v.exp_rdata);
        check($sformatf("t%0d_wrong_port_done", idx), wrong_done, 1'b0);
        check($sformatf("t%0d_stall", idx), stall_bad, 1'b0);
        @(negedge clk);
        check($sformatf("t%0d_after_done", idx), {bus.busy, bus.i_done, bus.d_done}, 3'b000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[8];
        int   rr_cyc[$];
        int   rr_port[$];
        int   exp_cyc[4];
        int   exp_port[4];
        logic both_done;
        int   late_done;

        clear_inputs();
        mem_store[16'h0040] = 16'hBEEF;

        // Reset values of both instances.
        @(negedge clk);
        check("rst_ctl", {bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done, bus.busy,
                          bus.i_stall, bus.d_stall}, '0);
        check("rst_data", {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}, '0);
        check("rst_ctl_lat1", {bus1.mem_en, bus1.mem_wr, bus1.i_done, bus1.d_done, bus1.busy}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed single transactions: {is_d, wr, addr, wdata, expected rdata}.
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h1000, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h1000, 16'h0000, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h0041, 16'h0000, 16'h5A1B};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};
        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Both ports held continuously after reset: D, I, D, I at LAT+3 spacing.
        do_reset();
        exp_cyc  = '{6, 13, 20, 27};
        exp_port = '{1, 0, 1, 0};
        both_done = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0100;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0200;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.i_done && bus.d_done) both_done = 1'b1;
            if (bus.d_done) begin rr_cyc.push_back(k); rr_port.push_back(1); end
            if (bus.i_done) begin rr_cyc.push_back(k); rr_port.push_back(0); end
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("rr_count", 64'(rr_cyc.size()), 64'd4);
        check("rr_both_done", both_done, 1'b0);
        for (int i = 0; i < 4 && i < rr_cyc.size(); i++) begin
            check($sformatf("rr%0d_cycle", i), 64'(rr_cyc[i]), 64'(exp_cyc[i]));
            check($sformatf("rr%0d_port", i), 64'(rr_port[i]), 64'(exp_port[i]));
        end
        repeat (10) @(posedge clk);
        #1;

        // Reset asserted during an I access: outputs clear at once, no late done.
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ctl", {bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done, bus.busy}, '0);
        check("abort_data", {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata}, '0);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        rst_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done || bus.busy) late_done++;
        end
        check("abort_no_done", 64'(late_done), 64'd0);
        @(posedge clk);
        #1;

        // LAT=1 instance: single D read, done three cycles after request.
        begin
            int          d1_at = -1;
            int          en1_at = -1;
            logic [15:0] rd1 = '0;
            bus1.d_req = 1'b1; bus1.d_wr = 1'b0; bus1.d_addr = 16'h2222;
            for (int k = 0; k < 10 && d1_at < 0; k++) begin
                @(negedge clk);
                if (bus1.mem_en && en1_at < 0) en1_at = k;
                if (bus1.d_done) begin d1_at = k; rd1 = bus1.d_rdata; end
                @(posedge clk);
                #1;
            end
            bus1.d_req = 1'b0;
            check("lat1_mem_en_cycle", 64'(en1_at), 64'd1);
            check("lat1_done_cycle", 64'(d1_at), 64'd3);
            check("lat1_rdata", rd1, 16'h7878);
        end

        // Random traffic against a schedule-level model.
        do_reset();
        model_mem = mem_store;
        begin
            logic        req[2], wr[2], drop[2];
            logic [15:0] addr[2], wdata[2];
            logic [15:0] exp_rd = '0;
            int          g = -100;
            int          own = 0;
            int          last = 0;
            logic        e_en, e_busy, e_di, e_dd, g_wr;
            logic [15:0] g_addr = '0, g_wdata = '0;
            g_wr = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[p] = 1'b0; wr[p] = 1'b0; drop[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
            end
            for (int n = 0; n < 600; n++) begin
                for (int p = 0; p < 2; p++) begin
                    if (drop[p]) begin req[p] = 1'b0; drop[p] = 1'b0; end
                    if (!req[p] && ($urandom_range(0, 2) == 0)) begin
                        req[p]   = 1'b1;
                        wr[p]    = (p == 1) && ($urandom_range(0, 1) == 1);
                        addr[p]  = 16'h3000 + 16'($urandom_range(0, 15));
                        wdata[p] = 16'($urandom);
                    end
                end
                bus.i_req = req[0]; bus.i_addr = addr[0];
                bus.d_req = req[1]; bus.d_wr = wr[1]; bus.d_addr = addr[1]; bus.d_wdata = wdata[1];
                @(negedge clk);
                if (n >= g + LAT + 3 && (req[0] || req[1])) begin
                    if (req[0] && req[1]) own = (last == 0) ? 1 : 0;
                    else                  own = req[1] ? 1 : 0;
                    last    = own;
                    g       = n;
                    g_wr    = (own == 1) && wr[1];
                    g_addr  = addr[own];
                    g_wdata = wdata[own];
                    if (g_wr) begin
                        model_mem[g_addr] = g_wdata;
                        exp_rd = '0;
                    end else begin
                        exp_rd = model_read(g_addr);
                    end
                end
                e_busy = (n >= g + 1) && (n <= g + LAT + 2);
                e_en   = (n == g + 1);
                e_di   = (n == g + LAT + 2) && (own == 0);
                e_dd   = (n == g + LAT + 2) && (own == 1);
                check("rnd_busy", bus.busy, e_busy);
                check("rnd_mem_en", bus.mem_en, e_en);
                check("rnd_i_done", bus.i_done, e_di);
                check("rnd_d_done", bus.d_done, e_dd);
                check("rnd_i_rdata", bus.i_rdata, e_di ? exp_rd : 16'h0000);
                check("rnd_d_rdata", bus.d_rdata, e_dd ? exp_rd : 16'h0000);
                check("rnd_stall", {bus.i_stall, bus.d_stall}, {req[0] & ~e_di, req[1] & ~e_dd});
                if (e_en) begin
                    check("rnd_mem_addr", bus.mem_addr, g_addr);
                    check("rnd_mem_wr", bus.mem_wr, g_wr);
                    if (g_wr) check("rnd_mem_wdata", bus.mem_wdata, g_wdata);
                end
                if (e_di) drop[0] = 1'b1;
                if (e_dd) drop[1] = 1'b1;
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single fixed-latency unified memory between the fetch-stage instruction port and the memory-stage data port of the 5-stage pipeline. Each requester holds a request until a one-cycle done pulse; the arbiter serialises accesses, round-robins on contention and drives per-port stall outputs. The stall outputs are ORed with the hazard stall by the pipeline control.

## Interface
Parameters:
- LAT, 4, memory read/write latency in cycles from the mem_en cycle; legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch read request; held until i_done.
- i_addr  in  16  fetch address; stable while i_req is high.
- i_rdata  out  16  fetch data; valid only while i_done is high.
- i_done  out  1  one-cycle completion pulse for the I port.
- i_stall  out  1  i_req & ~i_done.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = write, 0 = read; stable with d_req.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_rdata  out  16  read data; valid only while d_done is high; 0 after a write.
- d_done  out  1  one-cycle completion pulse for the D port.
- d_stall  out  1  d_req & ~d_done.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  16  registered access address.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  memory read data; valid exactly LAT cycles after mem_en.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE with no request: stay in IDLE.
- IDLE with only one request: grant that port.
- IDLE with both requests: grant the port that was not the last owner. last_owner resets to I, so D wins the first tie.
- On grant, latch the owner, address, wr and wdata. Set last_owner to the granted port. Go to ACCESS with cnt = 0.
- ACCESS: mem_en = 1 only while cnt = 0. mem_addr, mem_wr and mem_wdata hold the latched values for the whole ACCESS state.
- cnt increments every ACCESS cycle. When cnt = LAT, capture mem_rdata into the owner's rdata register (0 if the access is a write) and go to DONE.
- DONE: the owner's done output = 1 and its rdata is driven. Next state is IDLE unconditionally. Requests seen in DONE are ignored; the finished requester is still holding req in that cycle.
- A request dropped during ACCESS is a protocol violation. The access still completes and done still pulses.
- Address and data changes after grant are ignored because the values are latched.
- Non-owner rdata outputs are 0. The done pulse is never asserted to a port that was not granted.
- cnt is 4 bits wide. It is compared for equality against LAT and never wraps within a legal LAT.

## Timing
- Reset values: state = IDLE, cnt = 0, last_owner = I. mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata and busy are all 0. Stalls follow their combinational definitions.
- Reset mid-ACCESS: return to IDLE immediately and drop any in-flight result. No done pulse occurs for the aborted access.
- Latency: request sampled in IDLE at cycle T → mem_en at T+1 → mem_rdata captured at the end of T+1+LAT → done at T+2+LAT. With LAT = 4, done arrives 6 cycles after request.
- Throughput: one access per LAT+3 cycles, because one IDLE cycle is always inserted between accesses.
- A waiting port gets the next grant. Worst-case wait is one full access of the other port.

## Structure
- Shared package `mem_pkg`: ADDR_W = 16, DATA_W = 16, owner encoding (OWN_I = 0, OWN_D = 1), FSM state enum.
- Sub-module `rr_pick2`: a 2-way round-robin picker. Inputs are req_i, req_d and last_owner; outputs are grant and grant_valid. It is combinational, and the last_owner register stays in `mem_arbiter`.

## Test plan
- Single I read, LAT = 4: i_req at T with i_addr = 0x0040, memory returns 0xBEEF → mem_en at T+1 with addr 0x0040 and mem_wr = 0; i_done = 1 with i_rdata = 0xBEEF at T+6 only; i_stall high T..T+5.
- D write: d_req with d_wr = 1, addr 0x1000, wdata 0x1234 → mem_wr = 1, mem_wdata = 0x1234 at T+1; d_done at T+6; d_rdata = 0.
- Simultaneous requests after reset → D granted first. I is granted in the IDLE cycle after d_done, so i_done arrives 7 cycles after d_done.
- Requests held continuously on both ports across 4 accesses → grant order D, I, D, I; no done pulse on the wrong port.
- rst_n low at T+3 of an I access → all outputs 0 asynchronously; after release with no requests, no i_done appears.
- LAT = 1 configuration: single D read → done 3 cycles after request, with data captured from the cycle after mem_en.
